// File: rtl/dlx_imem_loader.sv
// rtl/dlx_imem_loader.sv - boot loader that writes a checksummed byte-framed image into DLX instruction memory
module dlx_imem_loader #(
   parameter int ADDR_W = 8
) (
   input  logic        clock_i,
   input  logic        reset_i,
   input  logic [7:0]  rx_data_i,
   input  logic        rx_valid_i,
   output logic        rx_ready_o,
   output logic        imem_we_o,
   output logic [31:0] imem_addr_o,
   output logic [31:0] imem_data_o,
   output logic        core_reset_o,
   output logic        done_o,
   output logic        error_o
);
   typedef enum logic [2:0] {
      S_INIT, S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK, S_RUN, S_ERROR
   } state_t;

   localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);

   state_t          state, state_next;
   logic [15:0]     len;
   logic [ADDR_W:0] word_idx;
   logic [1:0]      byte_cnt;
   logic [23:0]     asm_q;
   logic [7:0]      csum;
   logic            accept;
   logic            word_last_byte;
   logic [16:0]     len_eval;
   logic [16:0]     words_done;

   logic            ready_d, we_d, core_reset_d, done_d, error_d;
   logic [31:0]     addr_d, data_d;

   assign accept         = rx_valid_i && rx_ready_o;
   assign word_last_byte = (state == S_DATA) && accept && (byte_cnt == 2'd3);
   assign len_eval       = {1'b0, len[15:8], rx_data_i};
   assign words_done     = 17'(word_idx) + 17'd1;

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) state <= S_INIT;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_INIT:   state_next = S_LEN_HI;
         S_LEN_HI: if (accept) state_next = S_LEN_LO;
         S_LEN_LO: if (accept) begin
            if (len_eval > MAX_WORDS)   state_next = S_ERROR;
            else if (len_eval == 17'd0) state_next = S_CHECK;
            else                        state_next = S_DATA;
         end
         S_DATA:   if (word_last_byte && words_done == {1'b0, len}) state_next = S_CHECK;
         S_CHECK:  if (accept) state_next = (rx_data_i == csum) ? S_RUN : S_ERROR;
         default:  state_next = state;
      endcase
   end

   // Outputs are registered, so they are derived from the state being entered.
   always_comb begin
      we_d         = 1'b0;
      addr_d       = imem_addr_o;
      data_d       = imem_data_o;
      if (word_last_byte) begin
         we_d   = 1'b1;
         addr_d = {{(29 - ADDR_W){1'b0}}, word_idx, 2'b00};
         data_d = {asm_q, rx_data_i};
      end
      ready_d      = (state_next == S_LEN_HI) || (state_next == S_LEN_LO) ||
                     (state_next == S_DATA)   || (state_next == S_CHECK);
      done_d       = (state_next == S_RUN);
      error_d      = (state_next == S_ERROR);
      core_reset_d = (state_next != S_RUN);
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         rx_ready_o   <= 1'b0;
         imem_we_o    <= 1'b0;
         imem_addr_o  <= 32'd0;
         imem_data_o  <= 32'd0;
         core_reset_o <= 1'b1;
         done_o       <= 1'b0;
         error_o      <= 1'b0;
      end else begin
         rx_ready_o   <= ready_d;
         imem_we_o    <= we_d;
         imem_addr_o  <= addr_d;
         imem_data_o  <= data_d;
         core_reset_o <= core_reset_d;
         done_o       <= done_d;
         error_o      <= error_d;
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         len      <= 16'd0;
         word_idx <= '0;
         byte_cnt <= 2'd0;
         asm_q    <= 24'd0;
         csum     <= 8'd0;
      end else if (accept) begin
         case (state)
            S_LEN_HI: begin
               len[15:8] <= rx_data_i;
               csum      <= csum ^ rx_data_i;
            end
            S_LEN_LO: begin
               len[7:0] <= rx_data_i;
               csum     <= csum ^ rx_data_i;
            end
            S_DATA: begin
               asm_q    <= {asm_q[15:0], rx_data_i};
               byte_cnt <= byte_cnt + 2'd1;
               csum     <= csum ^ rx_data_i;
               if (byte_cnt == 2'd3) word_idx <= word_idx + {{ADDR_W{1'b0}}, 1'b1};
            end
            default: ;
         endcase
      end
   end
endmodule
